// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM for a shared-ALU, unified-memory datapath.
// Optional RVMC_PERF_CNT_EN adds cycle_cnt/instret_cnt performance counters.
module riscv_multicycle_ctrl #(
  parameter int ALU_CTRL_W     = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_w,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_w,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  fault,
  output logic [3:0]            state_o
`ifdef RVMC_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXER   = 4'd6,  S_EXEI  = 4'd7,
    S_ALUWB  = 4'd8,  S_JAL    = 4'd9,  S_BEQ    = 4'd10, S_FAULT = 4'd15
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b011);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b101);

  // Returns {legal, alu_control}; an unsupported funct3 is reported as illegal.
  function automatic logic [ALU_CTRL_W:0] alu_decode(input logic [2:0] f3, input logic use_sub);
    logic [ALU_CTRL_W:0] r;
    case (f3)
      3'b000:  r = {1'b1, (use_sub ? ALU_SUB : ALU_ADD)};
      3'b010:  r = {1'b1, ALU_SLT};
      3'b110:  r = {1'b1, ALU_OR};
      3'b111:  r = {1'b1, ALU_AND};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

  state_t                state_r;
  logic [CNT_W-1:0]      wait_cnt_r;
  logic                  waiting_s;
  logic                  timeout_s;
  logic [ALU_CTRL_W:0]   alu_dec_s;
  logic                  alu_legal_s;

  logic                  mem_req_s, mem_w_s, adr_src_s, ir_write_s, pc_write_s, reg_w_s;
  logic [1:0]            result_src_s, alu_src_a_s, alu_src_b_s, imm_src_s;
  logic [ALU_CTRL_W-1:0] alu_control_s;

  assign waiting_s   = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
  assign timeout_s   = waiting_s && !mem_ready && (wait_cnt_r == WAIT_LIMIT);
  assign alu_dec_s   = alu_decode(funct3, (state_r == S_EXER) && funct7b5);
  assign alu_legal_s = alu_dec_s[ALU_CTRL_W];

  // Main sequencer: FAULT is absorbing until reset.
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      state_r <= S_FETCH;
    end else begin
      case (state_r)
        S_FETCH:  if (mem_ready) state_r <= S_DECODE; else if (timeout_s) state_r <= S_FAULT;
        S_DECODE: begin
          case (opcode)
            7'b0000011, 7'b0100011: state_r <= S_MEMADR;
            7'b0110011:             state_r <= S_EXER;
            7'b0010011:             state_r <= S_EXEI;
            7'b1101111:             state_r <= S_JAL;
            7'b1100011:             state_r <= S_BEQ;
            default:                state_r <= S_FAULT;
          endcase
        end
        S_MEMADR: state_r <= opcode[5] ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_r <= S_MEMWB; else if (timeout_s) state_r <= S_FAULT;
        S_MEMWB:  state_r <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_r <= S_FETCH; else if (timeout_s) state_r <= S_FAULT;
        S_EXER,
        S_EXEI:   state_r <= alu_legal_s ? S_ALUWB : S_FAULT;
        S_ALUWB:  state_r <= S_FETCH;
        S_JAL:    state_r <= S_ALUWB;
        S_BEQ:    state_r <= S_FETCH;
        S_FAULT:  state_r <= S_FAULT;
        default:  state_r <= S_FAULT;
      endcase
    end
  end

  // Consecutive not-ready cycles in the current memory state; any exit clears it.
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      wait_cnt_r <= '0;
    end else if (waiting_s && !mem_ready && !timeout_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Moore output decode; FETCH strobes and BEQ pc_write also follow mem_ready/zero.
  always_comb begin
    mem_req_s     = 1'b0;
    mem_w_s       = 1'b0;
    adr_src_s     = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    reg_w_s       = 1'b0;
    result_src_s  = 2'b00;
    alu_src_a_s   = 2'b00;
    alu_src_b_s   = 2'b00;
    imm_src_s     = 2'b00;
    alu_control_s = ALU_ADD;
    case (state_r)
      S_FETCH: begin
        mem_req_s   = 1'b1;
        alu_src_b_s = 2'b10;
        ir_write_s  = mem_ready;
        pc_write_s  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        imm_src_s   = 2'b10;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (opcode[5]) imm_src_s = 2'b01; else imm_src_s = 2'b00;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_w_s      = 1'b1;
      end
      S_MEMWR: begin
        mem_req_s = 1'b1;
        mem_w_s   = 1'b1;
        adr_src_s = 1'b1;
      end
      S_EXER: begin
        alu_src_a_s   = 2'b10;
        alu_src_b_s   = 2'b00;
        alu_control_s = alu_dec_s[ALU_CTRL_W-1:0];
      end
      S_EXEI: begin
        alu_src_a_s   = 2'b10;
        alu_src_b_s   = 2'b01;
        imm_src_s     = 2'b00;
        alu_control_s = alu_dec_s[ALU_CTRL_W-1:0];
      end
      S_ALUWB: begin
        result_src_s = 2'b00;
        reg_w_s      = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_s   = 2'b10;
        alu_src_b_s   = 2'b00;
        alu_control_s = ALU_SUB;
        pc_write_s    = zero;
      end
      S_FAULT: begin
        mem_req_s = 1'b0;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Strobes are forced low while reset is held so an in-flight access is dropped at once.
  assign mem_req     = mem_req_s  & srst;
  assign mem_w       = mem_w_s    & srst;
  assign ir_write    = ir_write_s & srst;
  assign pc_write    = pc_write_s & srst;
  assign reg_w       = reg_w_s    & srst;
  assign adr_src     = adr_src_s;
  assign result_src  = result_src_s;
  assign alu_src_a   = alu_src_a_s;
  assign alu_src_b   = alu_src_b_s;
  assign imm_src     = imm_src_s;
  assign alu_control = alu_control_s;
  assign fault       = (state_r == S_FAULT);
  assign state_o     = state_r;

`ifdef RVMC_PERF_CNT_EN
  logic [31:0] cycle_cnt_r;
  logic [31:0] instret_cnt_r;
  logic        retire_s;

  assign retire_s = (state_r == S_MEMWB) || (state_r == S_ALUWB) || (state_r == S_BEQ) ||
                    ((state_r == S_MEMWR) && mem_ready);

  // Free-running cycle and retired-instruction counters, frozen once faulted.
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      cycle_cnt_r   <= 32'd0;
      instret_cnt_r <= 32'd0;
    end else if (state_r != S_FAULT) begin
      cycle_cnt_r   <= cycle_cnt_r + 32'd1;
      instret_cnt_r <= instret_cnt_r + (retire_s ? 32'd1 : 32'd0);
    end else begin
      cycle_cnt_r   <= cycle_cnt_r;
      instret_cnt_r <= instret_cnt_r;
    end
  end

  assign cycle_cnt   = cycle_cnt_r;
  assign instret_cnt = instret_cnt_r;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: per-cycle expected outputs are queued
// with each stimulus step and compared on the following falling edge.
module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       srst = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, fault;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;
`ifdef RVMC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [21:0] exp;
  } sb_t;
  sb_t sb_q[$];

  riscv_multicycle_ctrl #(.ALU_CTRL_W(3), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .srst(srst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_w(mem_w),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_w(reg_w),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .fault(fault), .state_o(state_o)
`ifdef RVMC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected output vector from the state table:
  // {state, fault, mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, result_src, a, b, imm, alu}
  function automatic logic [21:0] model(input logic [3:0] st, input logic rdy, input logic z,
                                        input logic [2:0] alu, input logic [6:0] op);
    logic f, mr, mw, ad, ir, pw, rw;
    logic [1:0] rs, a, b, im;
    logic [2:0] al;
    {f, mr, mw, ad, ir, pw, rw} = 7'b0;
    {rs, a, b, im} = 8'b0;
    al = 3'b000;
    case (st)
      4'd0:  begin mr = 1'b1; b = 2'b10; ir = rdy; pw = rdy; end
      4'd1:  begin a = 2'b01; b = 2'b01; im = 2'b10; end
      4'd2:  begin a = 2'b10; b = 2'b01; im = op[5] ? 2'b01 : 2'b00; end
      4'd3:  begin mr = 1'b1; ad = 1'b1; end
      4'd4:  begin rs = 2'b01; rw = 1'b1; end
      4'd5:  begin mr = 1'b1; mw = 1'b1; ad = 1'b1; end
      4'd6:  begin a = 2'b10; b = 2'b00; al = alu; end
      4'd7:  begin a = 2'b10; b = 2'b01; im = 2'b00; al = alu; end
      4'd8:  begin rw = 1'b1; end
      4'd9:  begin a = 2'b01; b = 2'b10; pw = 1'b1; end
      4'd10: begin a = 2'b10; b = 2'b00; al = 3'b001; pw = z; end
      4'd15: begin f = 1'b1; end
      default: begin f = 1'b1; end
    endcase
    return {st, f, mr, mw, ad, ir, pw, rw, rs, a, b, im, al};
  endfunction

  // Scoreboard consumer: compare one queued expectation per falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check(e.tag, {10'd0, state_o, fault, mem_req, mem_w, adr_src, ir_write, pc_write, reg_w,
                    result_src, alu_src_a, alu_src_b, imm_src, alu_control}, {10'd0, e.exp});
    end
  end

  task automatic step(input string tag, input logic [3:0] st, input logic rdy,
                      input logic z, input logic [2:0] alu);
    mem_ready = rdy;
    zero = z;
    sb_q.push_back('{tag, model(st, rdy, z, alu, opcode)});
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op;
    funct3 = f3;
    funct7b5 = f7;
  endtask

  task automatic do_reset(input string tag);
    srst = 1'b0;
    #2;
    check({tag, "_state"}, {28'd0, state_o}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_mem_w"}, {31'd0, mem_w}, 32'd0);
    @(posedge clk);
    #1;
    srst = 1'b1;
  endtask

  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [2:0] alu);
    set_instr(op, f3, f7);
    step({tag, "_fetch"}, 4'd0, 1'b1, 1'b0, 3'b000);
    step({tag, "_decode"}, 4'd1, 1'b1, 1'b0, 3'b000);
    step({tag, "_exe"}, (op == 7'b0110011) ? 4'd6 : 4'd7, 1'b1, 1'b0, alu);
    step({tag, "_aluwb"}, 4'd8, 1'b1, 1'b0, 3'b000);
  endtask

  initial begin
    do_reset("rst0");

    run_alu("add", 7'b0110011, 3'b000, 1'b0, 3'b000);
    run_alu("sub", 7'b0110011, 3'b000, 1'b1, 3'b001);
    run_alu("addi_f7", 7'b0010011, 3'b000, 1'b1, 3'b000);
    run_alu("slti", 7'b0010011, 3'b010, 1'b0, 3'b101);
    run_alu("ori", 7'b0010011, 3'b110, 1'b0, 3'b011);
    run_alu("and", 7'b0110011, 3'b111, 1'b0, 3'b010);

    // LW with three not-ready cycles in MEMRD
    set_instr(7'b0000011, 3'b010, 1'b0);
    step("lw_fetch", 4'd0, 1'b1, 1'b0, 3'b000);
    step("lw_decode", 4'd1, 1'b1, 1'b0, 3'b000);
    step("lw_memadr", 4'd2, 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) step("lw_memrd_wait", 4'd3, 1'b0, 1'b0, 3'b000);
    step("lw_memrd_done", 4'd3, 1'b1, 1'b0, 3'b000);
    step("lw_memwb", 4'd4, 1'b1, 1'b0, 3'b000);

    // SW completing after one stall
    set_instr(7'b0100011, 3'b010, 1'b0);
    step("sw_fetch", 4'd0, 1'b1, 1'b0, 3'b000);
    step("sw_decode", 4'd1, 1'b1, 1'b0, 3'b000);
    step("sw_memadr", 4'd2, 1'b1, 1'b0, 3'b000);
    step("sw_memwr_wait", 4'd5, 1'b0, 1'b0, 3'b000);
    step("sw_memwr_done", 4'd5, 1'b1, 1'b0, 3'b000);

    // BEQ taken and not taken
    set_instr(7'b1100011, 3'b000, 1'b0);
    step("beq1_fetch", 4'd0, 1'b1, 1'b0, 3'b000);
    step("beq1_decode", 4'd1, 1'b1, 1'b0, 3'b000);
    step("beq1_taken", 4'd10, 1'b1, 1'b1, 3'b000);
    step("beq0_fetch", 4'd0, 1'b1, 1'b0, 3'b000);
    step("beq0_decode", 4'd1, 1'b1, 1'b0, 3'b000);
    step("beq0_not_taken", 4'd10, 1'b1, 1'b0, 3'b000);

    // JAL
    set_instr(7'b1101111, 3'b000, 1'b0);
    step("jal_fetch", 4'd0, 1'b1, 1'b0, 3'b000);
    step("jal_decode", 4'd1, 1'b1, 1'b0, 3'b000);
    step("jal_jal", 4'd9, 1'b1, 1'b0, 3'b000);
    step("jal_aluwb", 4'd8, 1'b1, 1'b0, 3'b000);

    // Ready arriving on the last allowed waiting cycle still proceeds
    set_instr(7'b0010011, 3'b000, 1'b0);
    for (int i = 0; i < 15; i++) step("limit_wait", 4'd0, 1'b0, 1'b0, 3'b000);
    step("limit_ready", 4'd0, 1'b1, 1'b0, 3'b000);
    step("limit_decode", 4'd1, 1'b1, 1'b0, 3'b000);
    step("limit_exei", 4'd7, 1'b1, 1'b0, 3'b000);
    step("limit_aluwb", 4'd8, 1'b1, 1'b0, 3'b000);

    // FETCH timeout after 16 waiting cycles, sticky until reset
    for (int i = 0; i < 16; i++) step("to_wait", 4'd0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) step("to_fault", 4'd15, 1'b1, 1'b0, 3'b000);
    do_reset("rst_fault");

    // Illegal opcode faults from DECODE
    set_instr(7'b1111111, 3'b000, 1'b0);
    step("illop_fetch", 4'd0, 1'b1, 1'b0, 3'b000);
    step("illop_decode", 4'd1, 1'b1, 1'b0, 3'b000);
    step("illop_fault", 4'd15, 1'b1, 1'b0, 3'b000);
    do_reset("rst_illop");

    // R-type funct3=001 faults from EXER
    set_instr(7'b0110011, 3'b001, 1'b0);
    step("illf3_fetch", 4'd0, 1'b1, 1'b0, 3'b000);
    step("illf3_decode", 4'd1, 1'b1, 1'b0, 3'b000);
    step("illf3_exer", 4'd6, 1'b1, 1'b0, 3'b000);
    step("illf3_fault", 4'd15, 1'b1, 1'b0, 3'b000);
    do_reset("rst_illf3");

    // Reset asserted mid-store drops the request immediately
    set_instr(7'b0100011, 3'b010, 1'b0);
    step("sw2_fetch", 4'd0, 1'b1, 1'b0, 3'b000);
    step("sw2_decode", 4'd1, 1'b1, 1'b0, 3'b000);
    step("sw2_memadr", 4'd2, 1'b1, 1'b0, 3'b000);
    step("sw2_memwr_wait", 4'd5, 1'b0, 1'b0, 3'b000);
    do_reset("rst_midwr");
    step("post_rst_fetch", 4'd0, 1'b0, 1'b0, 3'b000);

`ifdef RVMC_PERF_CNT_EN
    do_reset("rst_perf");
    check("perf_cycle_rst", cycle_cnt, 32'd0);
    check("perf_instret_rst", instret_cnt, 32'd0);
    for (int i = 0; i < 3; i++) run_alu("perf_addi", 7'b0010011, 3'b000, 1'b0, 3'b000);
    check("perf_cycle", cycle_cnt, 32'd12);
    check("perf_instret", instret_cnt, 32'd3);
`endif

    @(negedge clk);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
